// File: rtl/conv_stream_mc.sv
// Streaming NUM_CH-kernel 3x3 convolution over a raster pixel stream with valid/ready on both sides.
// Optional build macro CONV_RELU_EN: clamp negative saturated channel results to zero.
module conv_stream_mc #(
   parameter int DATA_W = 8,
   parameter int WGT_W  = 8,
   parameter int OUT_W  = 16,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int NUM_CH = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_i,
   input  logic                         wgt_we_i,
   input  logic [$clog2(NUM_CH*9)-1:0]  wgt_addr_i,
   input  logic signed [WGT_W-1:0]      wgt_data_i,
   input  logic                         pix_valid_i,
   output logic                         pix_ready_o,
   input  logic signed [DATA_W-1:0]     pix_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [NUM_CH*OUT_W-1:0]      out_data_o,
   output logic                         out_last_o,
   output logic                         busy_o,
   output logic                         done_o
);
   localparam int NW     = NUM_CH*9;
   localparam int AW     = $clog2(NUM_CH*9);
   localparam int PROD_W = DATA_W + WGT_W;
   localparam int ACC_W  = PROD_W + 4;
   localparam int CW     = $clog2(IMG_W);
   localparam int RW     = $clog2(IMG_H);
   localparam logic signed [ACC_W-1:0] SMAX = (ACC_W'(1) <<< (OUT_W-1)) - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e                   state_q;
   logic                     busy_q, done_q;
   logic [CW-1:0]            col_q;
   logic [RW-1:0]            row_q;
   logic signed [WGT_W-1:0]  wgt_q [NW];
   logic signed [DATA_W-1:0] lb0_q [IMG_W];
   logic signed [DATA_W-1:0] lb1_q [IMG_W];
   logic signed [DATA_W-1:0] win_q [9];
   logic                     win_vld_q, win_last_q;
   logic                     out_valid_q, out_last_q;
   logic [NUM_CH*OUT_W-1:0]  out_data_q, sum_d;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc;
   logic signed [OUT_W-1:0]  res;
   logic                     en, pix_acc, last_pix, win_ok;

   assign en          = !out_valid_q || out_ready_i;
   assign pix_ready_o = (state_q == RUN) && en;
   assign pix_acc     = pix_valid_i && pix_ready_o;
   assign last_pix    = (row_q == RW'(IMG_H-1)) && (col_q == CW'(IMG_W-1));
   assign win_ok      = (row_q >= RW'(2)) && (col_q >= CW'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start_i) begin
               state_q <= RUN;
               busy_q  <= 1'b1;
               col_q   <= '0;
               row_q   <= '0;
            end
            RUN: if (pix_acc) begin
               if (last_pix) state_q <= DRAIN;
               if (col_q == CW'(IMG_W-1)) begin
                  col_q <= '0;
                  row_q <= row_q + RW'(1);
               end else begin
                  col_q <= col_q + CW'(1);
               end
            end
            DRAIN: if (out_valid_q && out_ready_i && out_last_q) begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NW; i++) wgt_q[i] <= '0;
      end else if (wgt_we_i && state_q == IDLE && wgt_addr_i < AW'(NW)) begin
         wgt_q[wgt_addr_i] <= wgt_data_i;
      end
   end

   // Oldest entries of lb0/lb1 are the pixels one and two rows above the incoming one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IMG_W; i++) begin
            lb0_q[i] <= '0;
            lb1_q[i] <= '0;
         end
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
         win_vld_q  <= 1'b0;
         win_last_q <= 1'b0;
      end else if (en) begin
         win_vld_q  <= pix_acc && win_ok;
         win_last_q <= pix_acc && last_pix;
         if (pix_acc) begin
            lb0_q[0] <= pix_data_i;
            lb1_q[0] <= lb0_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
               lb0_q[i] <= lb0_q[i-1];
               lb1_q[i] <= lb1_q[i-1];
            end
            for (int r = 0; r < 3; r++) begin
               win_q[r*3]   <= win_q[r*3+1];
               win_q[r*3+1] <= win_q[r*3+2];
            end
            win_q[2] <= lb1_q[IMG_W-1];
            win_q[5] <= lb0_q[IMG_W-1];
            win_q[8] <= pix_data_i;
         end
      end
   end

   always_comb begin
      sum_d = '0;
      prod  = '0;
      acc   = '0;
      res   = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         acc = '0;
         for (int t = 0; t < 9; t++) begin
            prod = win_q[t] * wgt_q[ch*9+t];
            acc  = acc + ACC_W'(prod);
         end
         if (acc > SMAX)      res = SMAX[OUT_W-1:0];
         else if (acc < SMIN) res = SMIN[OUT_W-1:0];
         else                 res = acc[OUT_W-1:0];
`ifdef CONV_RELU_EN
         if (res[OUT_W-1]) res = '0;
`else
`endif
         sum_d[ch*OUT_W +: OUT_W] = res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (en) begin
         out_valid_q <= win_vld_q;
         out_last_q  <= win_vld_q && win_last_q;
         if (win_vld_q) out_data_q <= sum_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
endmodule

// File: tb/tb_conv_stream_mc.sv
// Directed + randomized bench for conv_stream_mc on a 4x4 frame with two kernels.
module tb_conv_stream_mc;
   localparam int W = 4, H = 4, NCH = 2, OW = 16;
   localparam int NW = NCH*9, NPIX = W*H, NOUT = (W-2)*(H-2);

   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, wgt_we = 1'b0;
   logic [4:0] wgt_addr = '0;
   logic signed [7:0] wgt_data = '0, pix_data = '0;
   logic pix_valid = 1'b0, pix_ready, out_valid, out_ready = 1'b0, out_last, busy, done;
   logic [NCH*OW-1:0] out_data;

   int n_vec = 0, n_err = 0;
   int wgt [NW];
   int pix [NPIX];
   int expv [NOUT][NCH];

   conv_stream_mc #(.DATA_W(8), .WGT_W(8), .OUT_W(OW), .IMG_W(W), .IMG_H(H), .NUM_CH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .wgt_we_i(wgt_we), .wgt_addr_i(wgt_addr),
      .wgt_data_i(wgt_data), .pix_valid_i(pix_valid), .pix_ready_o(pix_ready), .pix_data_i(pix_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
      .busy_o(busy), .done_o(done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] chan(input int ch);
      logic signed [OW-1:0] v;
      v = out_data[ch*OW +: OW];
      return 64'(v);
   endfunction

   // Reference: direct 3x3 dot product per window, then clamp.
   function automatic void model();
      for (int y = 2; y < H; y++)
         for (int x = 2; x < W; x++)
            for (int ch = 0; ch < NCH; ch++) begin
               longint s = 0;
               for (int r = 0; r < 3; r++)
                  for (int c = 0; c < 3; c++)
                     s += pix[(y-2+r)*W + (x-2+c)] * wgt[ch*9 + r*3 + c];
               if (s > 32767) s = 32767;
               if (s < -32768) s = -32768;
`ifdef CONV_RELU_EN
               if (s < 0) s = 0;
`else
`endif
               expv[(y-2)*(W-2) + (x-2)][ch] = int'(s);
            end
   endfunction

   task automatic load_wgt();
      @(posedge clk); #1;
      for (int i = 0; i < NW; i++) begin
         wgt_we = 1'b1; wgt_addr = 5'(i); wgt_data = 8'(wgt[i]);
         @(posedge clk); #1;
      end
      wgt_we = 1'b0;
   endtask

   task automatic set_basic();
      for (int i = 0; i < NW; i++) wgt[i] = (i >= 9) ? 1 : (i == 4 ? 1 : 0);
      for (int i = 0; i < NPIX; i++) pix[i] = i;
   endtask

   // vmode: 0 always valid, 1 every other cycle, 2 random. rmode: 0 always ready, 1 random, 2 stall 5 at first output.
   task automatic run_frame(input int vmode, input int rmode, input bit ign, input bit rst_mid);
      int idx = 0, nout = 0, cyc = 0, stall = 0, dones = 0, done_cyc = -1, acc_cyc = -1, vld_cyc = -1;
      bit stalled = 0, in_stall;
      model();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
         case (vmode)
            0: pix_valid = (idx < NPIX);
            1: pix_valid = (idx < NPIX) && (cyc % 2 == 0);
            default: pix_valid = (idx < NPIX) && ($urandom_range(0, 1) == 1);
         endcase
         pix_data = 8'(pix[idx < NPIX ? idx : 0]);
         if (rmode == 2 && out_valid && !stalled) begin stalled = 1; stall = 5; end
         out_ready = (rmode == 1) ? ($urandom_range(0, 3) != 0) : (stall == 0);
         in_stall = (rmode == 2) && (stall > 0);
         if (stall > 0) stall--;
         wgt_we = ign && cyc == 3; wgt_addr = 5'd4; wgt_data = 8'sd99; start = ign && cyc == 3;
         @(negedge clk);
         if (in_stall) begin
            chk("stall_valid", 64'(out_valid), 1);
            chk("stall_ch0", chan(0), expv[0][0]);
            chk("stall_ch1", chan(1), expv[0][1]);
            chk("stall_pix_ready", 64'(pix_ready), 0);
         end
         if (pix_valid && pix_ready) begin
            if (idx == 2*W + 2) acc_cyc = cyc;
            idx++;
         end
         if (out_valid && vld_cyc < 0) vld_cyc = cyc;
         if (out_valid && out_ready) begin
            chk("out_count_ok", 64'(nout < NOUT), 1);
            if (nout < NOUT) begin
               chk("out_ch0", chan(0), expv[nout][0]);
               chk("out_ch1", chan(1), expv[nout][1]);
               chk("out_last", 64'(out_last), 64'(nout == NOUT-1));
            end
            nout++;
         end
         if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
         if (rst_mid && idx == 8) begin
            rst_n = 1'b0; #1;
            chk("rst_out_valid", 64'(out_valid), 0);
            chk("rst_out_data", 64'(out_data), 0);
            chk("rst_out_last", 64'(out_last), 0);
            chk("rst_pix_ready", 64'(pix_ready), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_done", 64'(done), 0);
            pix_valid = 1'b0; out_ready = 1'b0; wgt_we = 1'b0; start = 1'b0;
            #8; rst_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      pix_valid = 1'b0; wgt_we = 1'b0; start = 1'b0;
      chk("frame_done_seen", 64'(done_cyc >= 0), 1);
      chk("out_total", nout, NOUT);
      chk("done_pulses", dones, 1);
      chk("idle_busy", 64'(busy), 0);
      chk("idle_pix_ready", 64'(pix_ready), 0);
      if (vmode == 0 && rmode == 0) chk("latency", vld_cyc - acc_cyc, 2);
   endtask

   initial begin
      #2;
      chk("reset_pix_ready", 64'(pix_ready), 0);
      chk("reset_out_valid", 64'(out_valid), 0);
      chk("reset_out_data", 64'(out_data), 0);
      chk("reset_out_last", 64'(out_last), 0);
      chk("reset_busy", 64'(busy), 0);
      chk("reset_done", 64'(done), 0);
      #10; rst_n = 1'b1;

      set_basic(); load_wgt();
      run_frame(0, 0, 0, 0);

      for (int i = 0; i < NW; i++) wgt[i] = 127;
      for (int i = 0; i < NPIX; i++) pix[i] = 127;
      load_wgt(); run_frame(0, 0, 0, 0);
      for (int i = 0; i < NW; i++) wgt[i] = -128;
      load_wgt(); run_frame(0, 0, 0, 0);

      set_basic(); load_wgt();
      run_frame(0, 2, 0, 0);
      run_frame(1, 0, 0, 0);
      run_frame(0, 0, 1, 0);

      run_frame(0, 0, 0, 1);
      load_wgt(); run_frame(0, 0, 0, 0);

      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < NW; i++) wgt[i] = int'($signed(8'($urandom)));
         for (int i = 0; i < NPIX; i++) pix[i] = int'($signed(8'($urandom)));
         load_wgt(); run_frame(2, 1, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
